// File: rtl/uart_pkt_tx.sv
// uart_pkt_tx: serializes a 24-bit command into MSB-first bytes for a UART transmitter.
//   clk, rst_n         clock, asynchronous active-low reset
//   snd_cmd, cmd[23:0] one-cycle start strobe and packet payload
//   tx_done            level done flag from the transmitter (paced on its rising edge)
//   trmt, tx_data[7:0] one-cycle frame start pulse and registered byte
//   busy, cmd_sent     packet in flight / packet complete
//   UART_PKT_CHKSUM_EN appends ~(sum of data bytes) as a trailing byte
module uart_pkt_tx #(
  parameter int NUM_BYTES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [23:0] cmd,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        cmd_sent
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
`ifdef UART_PKT_CHKSUM_EN
  localparam int N = NUM_BYTES + 1;
`else
  localparam int N = NUM_BYTES;
`endif
  localparam logic [1:0]  LAST = 2'(N - 1);
  localparam logic [31:0] MASK = ~(32'hFFFF_FFFF >> (8 * NUM_BYTES));
  state_t      r_state, w_next_state;
  logic [31:0] r_pkt, w_data, w_load;
  logic [7:0]  r_tx_data;
  logic [1:0]  r_byte_cnt;
  logic        r_tx_done_q, r_cmd_sent, w_done_rise, w_start, w_adv, w_fin;
  assign w_data = {cmd, 8'h00} & MASK;
`ifdef UART_PKT_CHKSUM_EN
  logic [7:0] w_chk;
  // unused byte lanes are masked to zero, so summing all three is safe for any NUM_BYTES
  assign w_chk  = ~(w_data[31:24] + w_data[23:16] + w_data[15:8]);
  assign w_load = w_data | ({24'h0, w_chk} << (8 * (3 - NUM_BYTES)));
`else
  assign w_load = w_data;
`endif
  // a stale high tx_done never advances the FSM; only its rising edge does
  assign w_done_rise = tx_done & ~r_tx_done_q;
  assign w_start     = (r_state == IDLE) & snd_cmd;
  assign w_adv       = (r_state == WAIT) & w_done_rise & (r_byte_cnt != LAST);
  assign w_fin       = (r_state == WAIT) & w_done_rise & (r_byte_cnt == LAST);
  assign trmt        = r_state == LOAD;
  assign busy        = r_state != IDLE;
  assign tx_data     = r_tx_data;
  assign cmd_sent    = r_cmd_sent;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next_state;
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = snd_cmd ? LOAD : IDLE;
      LOAD:    w_next_state = WAIT;
      WAIT:    w_next_state = w_fin ? IDLE : (w_adv ? LOAD : WAIT);
      default: w_next_state = IDLE;
    endcase
  end
  // the byte is loaded on the edge that enters LOAD, so it is valid for the whole trmt cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tx_done_q <= 1'b0;
      r_tx_data   <= 8'h00;
      r_pkt       <= 32'h0;
      r_byte_cnt  <= 2'd0;
      r_cmd_sent  <= 1'b0;
    end else begin
      r_tx_done_q <= tx_done;
      if (w_start) begin
        r_tx_data  <= w_load[31:24];
        r_pkt      <= w_load << 8;
        r_byte_cnt <= 2'd0;
        r_cmd_sent <= 1'b0;
      end else if (w_adv) begin
        r_tx_data  <= r_pkt[31:24];
        r_pkt      <= r_pkt << 8;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end else if (w_fin) r_cmd_sent <= 1'b1;
    end
endmodule

// File: tb/tb_uart_pkt_tx.sv
// tb_uart_pkt_tx: scoreboard bench for uart_pkt_tx with a behavioural UART transmitter.
module tb_uart_pkt_tx;
`ifdef UART_PKT_CHKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif
  logic        clk = 1'b0, rst_n, snd_cmd, tx_done, trmt, busy, cmd_sent;
  logic [23:0] cmd;
  logic [7:0]  tx_data;
  logic [7:0]  q[$];
  int          n_cmp = 0, n_err = 0;
  bit          abort = 1'b0, mon_prev = 1'b0;
  uart_pkt_tx dut (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd), .tx_done(tx_done),
    .trmt(trmt), .tx_data(tx_data), .busy(busy), .cmd_sent(cmd_sent)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic logic [7:0] chk_of(input logic [23:0] c);
    case (c)
      24'hA51234: chk_of = 8'h14;
      24'h00FF01: chk_of = 8'hFF;
      24'h123456: chk_of = 8'h63;
      24'h808080: chk_of = 8'h7F;
      default:    chk_of = 8'hxx;
    endcase
  endfunction
  task automatic send(input logic [23:0] c);
    cmd = c;
    snd_cmd = 1'b1;
    q.push_back(c[23:16]);
    q.push_back(c[15:8]);
    q.push_back(c[7:0]);
`ifdef UART_PKT_CHKSUM_EN
    q.push_back(chk_of(c));
`endif
    @(negedge clk);
    snd_cmd = 1'b0;
    check("start_busy", busy, 1);
    check("start_cmd_sent", cmd_sent, 0);
    check("start_trmt", trmt, 1);
  endtask
  task automatic wait_sent();
    for (int i = 0; i < 400 && !cmd_sent; i++) @(negedge clk);
    check("cmd_sent", cmd_sent, 1);
    check("busy_end", busy, 0);
    check("q_drained", q.size(), 0);
  endtask
  task automatic wait_bytes_left(input int n);
    for (int i = 0; i < 200 && q.size() > n; i++) @(negedge clk);
    check("q_wait", q.size(), n);
  endtask
  initial forever begin
    @(negedge clk);
    if (trmt) begin
      check("trmt_back2back", mon_prev, 0);
      if (q.size() == 0) check("trmt_unexpected", trmt, 0);
      else check("tx_data", tx_data, q.pop_front());
    end
    mon_prev = trmt;
  end
  initial forever begin
    @(negedge clk);
    while (trmt) begin
      tx_done = 1'b0;
      repeat (20) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      if (!abort) check("next_after_done", trmt | cmd_sent, 1);
      abort = 1'b0;
    end
  end
  initial begin
    rst_n = 1'b0;
    tx_done = 1'b1;
    snd_cmd = 1'b0;
    cmd = 24'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_sent", cmd_sent, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_trmt", trmt, 0);
    end
    check("idle_busy", busy, 0);
    send(24'hA51234);
    wait_sent();
    check("b2b_tx_done_high", tx_done, 1);
    send(24'h00FF01);
    wait_sent();
    repeat (2) @(negedge clk);
    send(24'h123456);
    wait_bytes_left(NB - 2);
    repeat (3) @(negedge clk);
    cmd = 24'hFFFFFF;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    check("ignored_busy", busy, 1);
    check("ignored_trmt", trmt, 0);
    wait_sent();
    repeat (2) @(negedge clk);
    send(24'h808080);
    wait_bytes_left(NB - 2);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    abort = 1'b1;
    #1;
    check("abort_trmt", trmt, 0);
    check("abort_tx_data", tx_data, 0);
    check("abort_busy", busy, 0);
    check("abort_cmd_sent", cmd_sent, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100 && !tx_done; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("post_abort_busy", busy, 0);
    send(24'hA51234);
    wait_sent();
    repeat (5) @(negedge clk);
    check("final_q", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
